// File: rtl/icache_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_pkg                                                       |
// | Shared widths, tag-word layout and controller state encoding.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package icache_pkg;

  localparam int TAG_W     = 22;
  localparam int IDX_W     = 6;
  localparam int OFF_W     = 4;
  localparam int VALID_BIT = 22;

  typedef enum logic [0:0] {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/icache_tag_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_tag_ctrl                                                  |
// | Tag-array controller: invalidate sweep, fills, 1-cycle lookups.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module icache_tag_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 6,
  parameter int OFF_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [ADDR_W-1:0] rsp_addr,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic              flush,
  output logic              busy,
  output logic              tag_csb0,
  output logic              tag_web0,
  output logic [IDX_W-1:0]  tag_addr0,
  output logic [TAG_W:0]    tag_din0,
  input  logic [TAG_W:0]    tag_dout0
);

  localparam logic [IDX_W-1:0] c_cnt_last = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    w_cnt_nxt;
  logic                r_rsp_valid;
  logic [ADDR_W-1:0]   r_req_addr;
  logic                w_accept;
  logic                w_unused;

  // Offset bits never reach the tag array.
  assign w_unused = ^{req_addr[OFF_W-1:0], fill_addr[OFF_W-1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= SWEEP;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_req_addr  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rsp_valid <= w_accept;
      if (w_accept) begin
        r_req_addr <= req_addr;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    tag_csb0    = 1'b1;
    tag_web0    = 1'b1;
    tag_addr0   = '0;
    tag_din0    = '0;
    req_ready   = 1'b0;
    fill_ready  = 1'b0;
    busy        = 1'b0;
    case (r_state)
      SWEEP: begin
        // Flush is ignored here: the sweep always runs to completion.
        busy      = 1'b1;
        tag_csb0  = 1'b0;
        tag_web0  = 1'b0;
        tag_addr0 = r_cnt;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == c_cnt_last) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        fill_ready = 1'b1;
        req_ready  = !fill_valid;
        if (fill_valid) begin
          // A fill coinciding with flush would be wiped by the sweep anyway.
          if (!flush) begin
            tag_csb0  = 1'b0;
            tag_web0  = 1'b0;
            tag_addr0 = fill_addr[OFF_W +: IDX_W];
            tag_din0  = {1'b1, fill_addr[ADDR_W-1 -: TAG_W]};
          end
        end else if (req_valid) begin
          w_accept  = 1'b1;
          tag_csb0  = 1'b0;
          tag_addr0 = req_addr[OFF_W +: IDX_W];
        end
        if (flush) begin
          w_state_nxt = SWEEP;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = SWEEP;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_addr  = r_req_addr;
  assign rsp_hit   = r_rsp_valid && tag_dout0[VALID_BIT] &&
                     (tag_dout0[TAG_W-1:0] == r_req_addr[ADDR_W-1 -: TAG_W]);

endmodule
`default_nettype wire

// File: tb/tb_icache_tag_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_icache_tag_ctrl                                               |
// | Directed scenarios plus randomized traffic against a tag model.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_icache_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [31:0] rsp_addr;
  logic        fill_valid;
  logic        fill_ready;
  logic [31:0] fill_addr;
  logic        flush;
  logic        busy;
  logic        tag_csb0;
  logic        tag_web0;
  logic [5:0]  tag_addr0;
  logic [22:0] tag_din0;
  logic [22:0] tag_dout0;

  int n_cmp = 0;
  int n_err = 0;

  icache_tag_ctrl #(.ADDR_W(32), .IDX_W(6), .OFF_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_addr(rsp_addr),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr),
    .flush(flush), .busy(busy),
    .tag_csb0(tag_csb0), .tag_web0(tag_web0), .tag_addr0(tag_addr0),
    .tag_din0(tag_din0), .tag_dout0(tag_dout0)
  );

  always #5 clk = ~clk;

  // Behavioural single-port tag SRAM, powered up with garbage.
  logic [22:0] mem [64];
  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 23'($urandom) | 23'h400000;
    tag_dout0 = 23'($urandom);
  end
  always @(posedge clk) begin
    if (tag_csb0 === 1'b0) begin
      if (tag_web0 === 1'b0) mem[tag_addr0] <= tag_din0;
      else                   tag_dout0 <= mem[tag_addr0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; fill_valid = 1'b0; flush = 1'b0;
    req_addr = '0; fill_addr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) tick();
    @(negedge clk);
    n_cmp++;
    if ({busy, req_ready, fill_ready, rsp_valid, rsp_hit, rsp_addr} !== {1'b1, 4'b0000, 32'h0}) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b rr=%b fr=%b rv=%b hit=%b ra=%h, want 1 0 0 0 0 0",
               busy, req_ready, fill_ready, rsp_valid, rsp_hit, rsp_addr);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      n_cmp++;
      if ({busy, tag_csb0, tag_web0, tag_addr0, tag_din0} !== {3'b100, 6'(i), 23'h0}) begin
        n_err++;
        $display("FAIL reset_sweep[%0d]: got busy=%b csb=%b web=%b addr=%0d din=%h",
                 i, busy, tag_csb0, tag_web0, tag_addr0, tag_din0);
      end
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({busy, req_ready, fill_ready, tag_csb0} !== 4'b0111) begin
      n_err++;
      $display("FAIL reset_run_entry: got busy=%b rr=%b fr=%b csb=%b, want 0 1 1 1",
               busy, req_ready, fill_ready, tag_csb0);
    end
  endtask

  task automatic test_lookup_miss();
    tick();
    req_valid = 1'b1; req_addr = 32'h0000_1230;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, tag_csb0, tag_web0, tag_addr0} !== {3'b101, 6'h23}) begin
      n_err++;
      $display("FAIL miss_issue: got rr=%b csb=%b web=%b addr=%h, want 1 0 1 23",
               req_ready, tag_csb0, tag_web0, tag_addr0);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_hit, rsp_addr} !== {2'b10, 32'h0000_1230}) begin
      n_err++;
      $display("FAIL miss_rsp: got rv=%b hit=%b ra=%h, want 1 0 00001230", rsp_valid, rsp_hit, rsp_addr);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_hit, tag_csb0} !== 3'b001) begin
      n_err++;
      $display("FAIL miss_idle: got rv=%b hit=%b csb=%b, want 0 0 1", rsp_valid, rsp_hit, tag_csb0);
    end
  endtask

  task automatic test_fill_hit();
    tick();
    fill_valid = 1'b1; fill_addr = 32'h0000_1230;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, fill_ready, tag_csb0, tag_web0, tag_addr0, tag_din0} !== {4'b0100, 6'h23, 23'h400004}) begin
      n_err++;
      $display("FAIL fill_issue: got rr=%b fr=%b csb=%b web=%b addr=%h din=%h",
               req_ready, fill_ready, tag_csb0, tag_web0, tag_addr0, tag_din0);
    end
    tick();
    fill_valid = 1'b0; req_valid = 1'b1; req_addr = 32'h0000_123C;
    @(negedge clk);
    tick();
    req_addr = 32'h0000_5230;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_hit, rsp_addr} !== {2'b11, 32'h0000_123C}) begin
      n_err++;
      $display("FAIL fill_hit: got rv=%b hit=%b ra=%h, want 1 1 0000123c", rsp_valid, rsp_hit, rsp_addr);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_hit, rsp_addr} !== {2'b10, 32'h0000_5230}) begin
      n_err++;
      $display("FAIL fill_tag_miss: got rv=%b hit=%b ra=%h, want 1 0 00005230", rsp_valid, rsp_hit, rsp_addr);
    end
  endtask

  task automatic test_fill_priority();
    tick();
    fill_valid = 1'b1; fill_addr = 32'h0000_2340;
    req_valid = 1'b1;  req_addr = 32'h0000_2340;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, tag_csb0, tag_web0, tag_addr0, tag_din0} !== {3'b000, 6'h34, 23'h400008}) begin
      n_err++;
      $display("FAIL prio_issue: got rr=%b csb=%b web=%b addr=%h din=%h",
               req_ready, tag_csb0, tag_web0, tag_addr0, tag_din0);
    end
    tick();
    fill_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_hit} !== 2'b00) begin
      n_err++;
      $display("FAIL prio_no_rsp: got rv=%b hit=%b, want 0 0", rsp_valid, rsp_hit);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_hit, rsp_addr} !== {2'b11, 32'h0000_2340}) begin
      n_err++;
      $display("FAIL prio_fill_written: got rv=%b hit=%b ra=%h, want 1 1 00002340", rsp_valid, rsp_hit, rsp_addr);
    end
  endtask

  task automatic test_flush();
    tick();
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_1230;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL flush_accept: got rr=%b busy=%b, want 1 0", req_ready, busy);
    end
    for (int i = 0; i < 64; i++) begin
      tick();
      idle_inputs();
      if (i == 10) flush = 1'b1;
      @(negedge clk);
      if (i == 0) begin
        n_cmp++;
        if ({rsp_valid, rsp_hit, rsp_addr} !== {2'b11, 32'h0000_1230}) begin
          n_err++;
          $display("FAIL flush_same_cycle_rsp: got rv=%b hit=%b ra=%h, want 1 1 00001230",
                   rsp_valid, rsp_hit, rsp_addr);
        end
      end
      n_cmp++;
      if ({busy, tag_csb0, tag_web0, tag_addr0, tag_din0} !== {3'b100, 6'(i), 23'h0}) begin
        n_err++;
        $display("FAIL flush_sweep[%0d]: got busy=%b csb=%b web=%b addr=%0d din=%h",
                 i, busy, tag_csb0, tag_web0, tag_addr0, tag_din0);
      end
    end
    tick();
    idle_inputs();
    req_valid = 1'b1; req_addr = 32'h0000_1230;
    @(negedge clk);
    n_cmp++;
    if ({busy, req_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL flush_done: got busy=%b rr=%b, want 0 1", busy, req_ready);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_hit} !== 2'b10) begin
      n_err++;
      $display("FAIL flush_invalidated: got rv=%b hit=%b, want 1 0", rsp_valid, rsp_hit);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    req_valid = 1'b1; req_addr = 32'h0000_1230; rst_n = 1'b0;
    @(negedge clk);
    tick();
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_hit, busy, tag_addr0} !== {3'b001, 6'd0}) begin
      n_err++;
      $display("FAIL reset_mid_lookup: got rv=%b hit=%b busy=%b addr=%0d, want 0 0 1 0",
               rsp_valid, rsp_hit, busy, tag_addr0);
    end
    for (int i = 1; i <= 30; i++) begin
      tick();
      @(negedge clk);
    end
    n_cmp++;
    if ({busy, tag_addr0} !== {1'b1, 6'd30}) begin
      n_err++;
      $display("FAIL reset_mid_reach30: got busy=%b addr=%0d, want 1 30", busy, tag_addr0);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      n_cmp++;
      if ({busy, tag_csb0, tag_web0, tag_addr0, tag_din0} !== {3'b100, 6'(i), 23'h0}) begin
        n_err++;
        $display("FAIL reset_mid_sweep[%0d]: got busy=%b csb=%b web=%b addr=%0d din=%h",
                 i, busy, tag_csb0, tag_web0, tag_addr0, tag_din0);
      end
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({busy, req_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_mid_done: got busy=%b rr=%b, want 0 1", busy, req_ready);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom_range(0, 3) * 1024) + ($urandom_range(0, 7) * 16) + $urandom_range(0, 15);
    if ($urandom_range(0, 7) == 0) a = $urandom;
    return a;
  endfunction

  // Reference: a table of 64 lines, each either invalid or holding addr/1024.
  task automatic test_random();
    bit          ref_v   [64];
    int unsigned ref_tag [64];
    bit          m_run  = 1'b1;
    int          m_left = 0;
    bit          exp_v  = 1'b0;
    bit          exp_hit = 1'b0;
    logic [31:0] exp_addr = '0;
    int          idx;
    for (int k = 0; k < 64; k++) ref_v[k] = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      req_valid  = ($urandom_range(0, 3) != 0);
      fill_valid = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 79) == 0);
      req_addr   = rand_addr();
      fill_addr  = rand_addr();
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_hit, busy, req_ready, fill_ready} !==
          {exp_v, exp_v & exp_hit, !m_run, m_run & !fill_valid, m_run}) begin
        n_err++;
        $display("FAIL rand[%0d]: got rv=%b hit=%b busy=%b rr=%b fr=%b, want %b %b %b %b %b",
                 cyc, rsp_valid, rsp_hit, busy, req_ready, fill_ready,
                 exp_v, exp_v & exp_hit, !m_run, m_run & !fill_valid, m_run);
      end
      if (exp_v) begin
        n_cmp++;
        if (rsp_addr !== exp_addr) begin
          n_err++;
          $display("FAIL rand_addr[%0d]: got %h, want %h", cyc, rsp_addr, exp_addr);
        end
      end
      exp_v = 1'b0;
      if (m_run) begin
        if (req_valid && !fill_valid) begin
          idx      = (req_addr / 16) % 64;
          exp_v    = 1'b1;
          exp_hit  = ref_v[idx] && (ref_tag[idx] == req_addr / 1024);
          exp_addr = req_addr;
        end
        if (fill_valid && !flush) begin
          idx          = (fill_addr / 16) % 64;
          ref_v[idx]   = 1'b1;
          ref_tag[idx] = fill_addr / 1024;
        end
        if (flush) begin
          m_run  = 1'b0;
          m_left = 64;
          for (int k = 0; k < 64; k++) ref_v[k] = 1'b0;
        end
      end else begin
        m_left--;
        if (m_left == 0) m_run = 1'b1;
      end
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_lookup_miss();
    test_fill_hit();
    test_fill_priority();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_tag_ctrl.md
ICACHE_TAG_CTRL -- requirements
Module: icache_tag_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_W, 32, byte address width; IDX_W, 6, set index bits; OFF_W, 4, line offset bits.
REQ-002 SHALL have ports, clock and reset first, as name  direction  width  meaning:
- clk  in  1  single clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  lookup request.
- req_ready  out  1  lookup accepted when high.
- req_addr  in  ADDR_W  fetch address.
- rsp_valid  out  1  lookup result valid.
- rsp_hit  out  1  tag match and valid.
- rsp_addr  out  ADDR_W  address of the responded lookup.
- fill_valid  in  1  write tag for a refilled line.
- fill_ready  out  1  fill accepted when high.
- fill_addr  in  ADDR_W  refilled line address.
- flush  in  1  one-cycle pulse, invalidate all sets.
- busy  out  1  sweep in progress.
- tag_csb0  out  1  SRAM chip select, active low.
- tag_web0  out  1  SRAM write enable, active low.
- tag_addr0  out  IDX_W  SRAM set index.
- tag_din0  out  23  SRAM write data.
- tag_dout0  in  23  SRAM read data.

Function
REQ-003 Tag word SHALL be bit 22 = valid, bits 21:0 = req_addr[31:10]; index = addr[9:4]; offset = addr[3:0], ignored.
REQ-004 SRAM timing SHALL be: controls sampled at the clk edge when tag_csb0=0; a write lands at the following edge; tag_dout0 reflects the sampled index in the cycle after sampling.
REQ-005 States SHALL be SWEEP and RUN.
REQ-006 SWEEP: tag_csb0=0, tag_web0=0, tag_din0=0, tag_addr0 = 6-bit counter starting at 0, +1 per cycle; req_ready=0, fill_ready=0, busy=1.
REQ-007 SWEEP SHALL exit to RUN in the cycle after index 63 is driven, i.e. exactly 64 write cycles; the counter wraps to 0.
REQ-008 RUN: fill_ready=1; req_ready = !fill_valid.
REQ-009 Fill has priority: when fill_valid in RUN, drive csb0=0, web0=0, addr0 = fill_addr[9:4], din0 = {1'b1, fill_addr[31:10]}.
REQ-010 Lookup accepted (req_valid && req_ready): drive csb0=0, web0=1, addr0 = req_addr[9:4]; register req_addr.
REQ-011 Lookup response SHALL come exactly 1 cycle after acceptance: rsp_valid=1, rsp_addr = registered address, rsp_hit = tag_dout0[22] && tag_dout0[21:0] == registered addr[31:10].
REQ-012 Throughput SHALL be one lookup per cycle, back-to-back.
REQ-013 A lookup accepted in the cycle after a fill to the same index SHALL observe the filled tag (hit).
REQ-014 Idle in RUN SHALL drive tag_csb0=1; rsp_valid SHALL be 0 in any cycle not following an acceptance.
REQ-015 flush in RUN SHALL enter SWEEP at the next edge with the counter at 0; a lookup accepted in the same cycle still responds; a fill in the same cycle is dropped.
REQ-016 flush during SWEEP SHALL be ignored; the counter does not restart.
REQ-017 rsp_hit SHALL be 0 whenever rsp_valid=0.

Reset
REQ-018 While rst_n=0 at an edge: state=SWEEP, counter=0, rsp_valid=0, rsp_hit=0, rsp_addr=0, busy=1, req_ready=0, fill_ready=0.
REQ-019 Reset asserted mid-sweep or mid-lookup SHALL restart the sweep from index 0 and discard any pending response.
REQ-020 SRAM contents have no reset; correctness after reset SHALL rely solely on the sweep.

Structure
REQ-021 Package icache_pkg SHALL hold: TAG_W=22, IDX_W=6, OFF_W=4, VALID_BIT=22, the state enum {SWEEP, RUN}.
REQ-022 No sub-module SHALL be created; the tag SRAM is instantiated by the parent icache and connected via the tag_* ports.

Verification
REQ-023 The bench SHALL cover these directed scenarios, using a behavioural tag SRAM model:
- Reset release -> busy=1 for 64 cycles, addr0 0..63 with din0=0; req_ready=1 on cycle 65.
- Lookup 0x0000_1230 after sweep -> rsp_valid next cycle, rsp_hit=0.
- Fill 0x0000_1230, then lookup 0x0000_123C the next cycle -> rsp_hit=1; lookup 0x0000_5230 -> rsp_hit=0.
- fill_valid and req_valid together -> req_ready=0, fill written, no rsp_valid next cycle.
- Flush after fill 0x0000_1230 -> 64-cycle sweep, then lookup 0x0000_1230 -> rsp_hit=0.
- rst_n low at sweep index 30 -> sweep restarts at 0, 64 full cycles.
